// File: rtl/fm_demod.sv
// rtl/fm_demod.sv - FM demodulator: conjugate cross product, restoring divide, linear angle approximation
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   i_in/i_empty      in-phase FIFO read data and empty flag
//   i_rd_en           in-phase FIFO pop (combinational)
//   q_in/q_empty      quadrature FIFO read data and empty flag
//   q_rd_en           quadrature FIFO pop (combinational)
//   y_out             demodulated sample (registered, held until next write)
//   y_full            output FIFO full flag
//   y_wr_en           output FIFO push (registered, one cycle per sample)
module fm_demod #(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10,
  parameter int GAIN       = 758
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_in,
  input  logic                  i_empty,
  output logic                  i_rd_en,
  input  logic [DATA_WIDTH-1:0] q_in,
  input  logic                  q_empty,
  output logic                  q_rd_en,
  output logic [DATA_WIDTH-1:0] y_out,
  input  logic                  y_full,
  output logic                  y_wr_en
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [W-1:0]  ONE_W    = W'(1);
  localparam logic [W-1:0]  C_QPI    = W'(804);   // QUANT(pi/4)
  localparam logic [W-1:0]  C_3QPI   = W'(2412);  // QUANT(3*pi/4)
  localparam logic [W-1:0]  GAIN_W   = W'(GAIN);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_READ,
    S_CROSS,
    S_DIV,
    S_ANGLE,
    S_WRITE
  } state_t;

  // Signed dequantize with truncation toward zero: bias negative values
  // by 2^BITS-1 before the arithmetic shift so they round up to zero.
  function automatic logic [W-1:0] deq(input logic [W-1:0] v);
    logic [W-1:0]        bias;
    logic signed [W-1:0] t;
    bias = '0;
    if (v[W-1]) bias[BITS-1:0] = '1;
    t = $signed(v + bias);
    return t >>> BITS;
  endfunction

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? (~v + ONE_W) : v;
  endfunction

  state_t        state_q,  state_d;
  logic [W-1:0]  i_q,      i_d;        // current captured sample
  logic [W-1:0]  q_q,      q_d;
  logic [W-1:0]  ip_q,     ip_d;       // previous captured sample
  logic [W-1:0]  qp_q,     qp_d;
  logic          re_neg_q, re_neg_d;
  logic          im_neg_q, im_neg_d;
  logic [W-1:0]  rem_q,    rem_d;      // divider partial remainder
  logic [W-1:0]  quo_q,    quo_d;      // dividend shifting out, quotient shifting in
  logic [W-1:0]  den_q,    den_d;      // divisor magnitude
  logic          q_neg_q,  q_neg_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [W-1:0]  result_q, result_d;
  logic [W-1:0]  y_out_q,  y_out_d;
  logic          y_wr_en_q, y_wr_en_d;

  logic pop;

  // Cross-product stage: products wrap modulo 2^W by construction.
  logic [W-1:0] re, im, im_abs, ay, num_pre, num, den, num_mag, den_mag;

  always_comb begin
    re      = deq(ip_q * i_q + qp_q * q_q);
    im      = deq(ip_q * q_q - qp_q * i_q);
    im_abs  = mag(im);
    ay      = im_abs + ONE_W;
    num_pre = '0;
    den     = '0;
    if (!re[W-1]) begin
      num_pre = re - ay;
      den     = re + ay;
    end else begin
      num_pre = re + ay;
      den     = ay - re;
    end
    num     = num_pre << BITS;
    num_mag = mag(num);
    den_mag = mag(den);
  end

  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract the divisor when it fits.
  logic [W:0]   rem_sh, rem_diff;
  logic [W-1:0] step_rem, step_quo;

  always_comb begin
    rem_sh   = {rem_q, quo_q[W-1]};
    rem_diff = rem_sh - {1'b0, den_q};
    step_rem = rem_sh[W-1:0];
    step_quo = {quo_q[W-2:0], 1'b0};
    if (!rem_diff[W]) begin
      step_rem = rem_diff[W-1:0];
      step_quo = {quo_q[W-2:0], 1'b1};
    end
  end

  // Angle stage: pi/4 - (pi/4)*r for the right half plane, 3pi/4 - (pi/4)*r
  // for the left, mirrored for negative imaginary part, then scaled.
  logic [W-1:0] quot, ang_base, ang_abs, ang, angle_result;

  always_comb begin
    quot         = q_neg_q ? (~quo_q + ONE_W) : quo_q;
    ang_base     = re_neg_q ? C_3QPI : C_QPI;
    ang_abs      = ang_base - deq(C_QPI * quot);
    ang          = im_neg_q ? (~ang_abs + ONE_W) : ang_abs;
    angle_result = deq(GAIN_W * ang);
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    q_d       = q_q;
    ip_d      = ip_q;
    qp_d      = qp_q;
    re_neg_d  = re_neg_q;
    im_neg_d  = im_neg_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    den_d     = den_q;
    q_neg_d   = q_neg_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    y_out_d   = y_out_q;
    y_wr_en_d = 1'b0;
    pop       = 1'b0;

    case (state_q)
      S_READ: begin
        if (!i_empty && !q_empty) begin
          pop     = 1'b1;
          i_d     = i_in;
          q_d     = q_in;
          state_d = S_CROSS;
        end
      end
      S_CROSS: begin
        ip_d     = i_q;
        qp_d     = q_q;
        re_neg_d = re[W-1];
        im_neg_d = im[W-1];
        rem_d    = '0;
        quo_d    = num_mag;
        den_d    = den_mag;
        q_neg_d  = num[W-1] ^ den[W-1];
        cnt_d    = '0;
        state_d  = S_DIV;
      end
      S_DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = S_ANGLE;
      end
      S_ANGLE: begin
        result_d = angle_result;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        if (!y_full) begin
          y_out_d   = result_q;
          y_wr_en_d = 1'b1;
          state_d   = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_READ;
      i_q       <= '0;
      q_q       <= '0;
      ip_q      <= '0;
      qp_q      <= '0;
      re_neg_q  <= 1'b0;
      im_neg_q  <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      den_q     <= '0;
      q_neg_q   <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      y_out_q   <= '0;
      y_wr_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      q_q       <= q_d;
      ip_q      <= ip_d;
      qp_q      <= qp_d;
      re_neg_q  <= re_neg_d;
      im_neg_q  <= im_neg_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      den_q     <= den_d;
      q_neg_q   <= q_neg_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      y_out_q   <= y_out_d;
      y_wr_en_q <= y_wr_en_d;
    end
  end

  // Both FIFOs pop together; state_q reads S_READ during reset, so mask it.
  assign i_rd_en = pop & ~reset;
  assign q_rd_en = pop & ~reset;
  assign y_out   = y_out_q;
  assign y_wr_en = y_wr_en_q;

endmodule

// File: tb/tb_fm_demod.sv
// tb/tb_fm_demod.sv - self-checking bench for fm_demod against an arithmetic reference model
module tb_fm_demod;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic signed [31:0] i_in = '0;
  logic signed [31:0] q_in = '0;
  logic               i_empty = 1'b1;
  logic               q_empty = 1'b1;
  logic               i_rd_en, q_rd_en;
  logic signed [31:0] y_out;
  logic               y_full = 1'b0;
  logic               y_wr_en;

  fm_demod dut (
    .clock   (clock),
    .reset   (reset),
    .i_in    (i_in),
    .i_empty (i_empty),
    .i_rd_en (i_rd_en),
    .q_in    (q_in),
    .q_empty (q_empty),
    .q_rd_en (q_rd_en),
    .y_out   (y_out),
    .y_full  (y_full),
    .y_wr_en (y_wr_en)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  int ip_m = 0, qp_m = 0;
  int exp_q[$];
  int popc_q[$];
  int last_y = 0;
  bit lat_check = 1'b1;
  int writes = 0;
  int pop_cyc = 0;
  int full_mode = 0;   // 0 = never full, 1 = full, 2 = random

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  function automatic int deq(input int v);
    return v / 1024;
  endfunction

  // Demodulator output straight from the arithmetic definition.
  function automatic int model(input int i, input int q, input int ip, input int qp);
    int re, im, ay, num, den, quot, ang;
    longint n, d;
    re = deq(ip * i + qp * q);
    im = deq(ip * q - qp * i);
    ay = ((im < 0) ? -im : im) + 1;
    if (re >= 0) begin
      num = (re - ay) * 1024;
      den = re + ay;
    end else begin
      num = (re + ay) * 1024;
      den = ay - re;
    end
    n    = num;
    d    = den;
    quot = int'(n / d);
    ang  = ((re >= 0) ? 804 : 2412) - deq(804 * quot);
    if (im < 0) ang = -ang;
    return deq(758 * ang);
  endfunction

  always @(posedge clock) begin
    #1;
    if (full_mode == 2) y_full = ($urandom_range(0, 99) < 30);
    else                y_full = (full_mode == 1);
  end

  always @(negedge clock) begin
    check("pop_pair", int'(i_rd_en), int'(q_rd_en));
    if (reset) check("pop_in_reset", int'(i_rd_en), 0);
    if (i_rd_en) begin
      check("pop_legal", int'(i_empty | q_empty), 0);
      exp_q.push_back(model(i_in, q_in, ip_m, qp_m));
      popc_q.push_back(cyc);
      ip_m = i_in;
      qp_m = q_in;
    end
    if (y_wr_en) begin
      writes++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_write: got y_out=%0d with nothing outstanding", y_out);
      end else begin
        int e, pc;
        e  = exp_q.pop_front();
        pc = popc_q.pop_front();
        check("y_out", y_out, e);
        if (lat_check) check("latency", cyc - pc, 36);
      end
      last_y = y_out;
    end else begin
      check("y_hold", y_out, last_y);
    end
  end

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    popc_q.delete();
    ip_m = 0;
    qp_m = 0;
    last_y = 0;
    i_empty = 1'b0;
    q_empty = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_y_out", y_out, 0);
    check("rst_y_wr_en", int'(y_wr_en), 0);
    check("rst_rd_en", int'(i_rd_en | q_rd_en), 0);
    i_empty = 1'b1;
    q_empty = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic push(input int a, input int b);
    bit got;
    got = 1'b0;
    @(posedge clock);
    #1;
    i_in = a;
    q_in = b;
    i_empty = 1'b0;
    q_empty = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clock);
      if (i_rd_en) begin
        got = 1'b1;
        pop_cyc = cyc;
        break;
      end
    end
    if (!got) timeout_fail("pop_wait");
    @(posedge clock);
    #1;
    i_empty = 1'b1;
    q_empty = 1'b1;
  endtask

  task automatic wait_write(output int val, output int wc);
    val = 0;
    wc  = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      if (y_wr_en) begin
        val = y_out;
        wc  = cyc;
        return;
      end
    end
    timeout_fail("write_wait");
  endtask

  task automatic drain();
    for (int n = 0; n < 400; n++) begin
      if (exp_q.size() == 0) return;
      @(negedge clock);
    end
    timeout_fail("drain");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int v, wc, e, w0;

    check("model_pin_a", model(1024, 0, 0, 0), 1190);
    check("model_pin_b", model(1024, 0, 1024, 0), 1);
    check("model_pin_c", model(0, -1024, 1024, 0), -1190);

    do_reset();

    push(1024, 0);
    wait_write(v, wc);
    check("first_y", v, 1190);
    check("first_lat", wc - pop_cyc, 36);

    push(1024, 0);
    wait_write(v, wc);
    check("same_y", v, 1);

    push(0, 1024);
    wait_write(v, wc);
    check("quarter_pos_y", v, 1190);

    push(1024, 0);
    wait_write(v, wc);
    push(0, -1024);
    wait_write(v, wc);
    check("quarter_neg_y", v, -1190);

    // Only the in-phase FIFO has data: nothing may pop.
    @(posedge clock);
    #1;
    i_in = 77;
    q_in = -55;
    i_empty = 1'b0;
    q_empty = 1'b1;
    w0 = writes;
    repeat (50) begin
      @(negedge clock);
      check("single_fifo_no_pop", int'(i_rd_en | q_rd_en), 0);
    end
    check("single_fifo_no_write", writes - w0, 0);
    @(posedge clock);
    #1;
    q_empty = 1'b0;
    @(negedge clock);
    check("both_pop_i", int'(i_rd_en), 1);
    check("both_pop_q", int'(q_rd_en), 1);
    @(posedge clock);
    #1;
    i_empty = 1'b1;
    q_empty = 1'b1;
    drain();

    // Output back-pressure held across S_WRITE.
    lat_check = 1'b0;
    e = model(300, -200, ip_m, qp_m);
    push(300, -200);
    full_mode = 1;
    repeat (55) begin
      @(negedge clock);
      check("stall_no_write", int'(y_wr_en), 0);
    end
    w0 = writes;
    full_mode = 0;
    wait_write(v, wc);
    check("stall_y", v, e);
    repeat (40) @(negedge clock);
    check("stall_single_pulse", writes - w0, 1);
    lat_check = 1'b1;

    // Reset while the divider is running.
    push(1024, 0);
    repeat (10) @(posedge clock);
    do_reset();
    repeat (50) begin
      @(negedge clock);
      check("abandon_no_write", int'(y_wr_en), 0);
      check("abandon_y_zero", y_out, 0);
    end
    push(1024, 0);
    wait_write(v, wc);
    check("post_reset_y", v, 1190);

    // Random back-to-back samples, latency checked.
    for (int k = 0; k < 30; k++) begin
      push(int'($urandom_range(0, 6000)) - 3000, int'($urandom_range(0, 6000)) - 3000);
    end
    drain();

    // Random samples with random gaps and random output back-pressure.
    lat_check = 1'b0;
    full_mode = 2;
    for (int k = 0; k < 30; k++) begin
      push(int'($urandom_range(0, 6000)) - 3000, int'($urandom_range(0, 6000)) - 3000);
      repeat ($urandom_range(0, 40)) @(posedge clock);
    end
    drain();
    full_mode = 0;
    repeat (5) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fm_demod.md
FM_DEMOD -- requirements
Module: fm_demod

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the sample width of I, Q and output (signed two's complement).
REQ-002 Parameter BITS, default 10, SHALL set the fixed-point fraction bits; QUANT(v)=v*2^BITS, DEQ(v)=v/2^BITS.
REQ-003 Parameter GAIN, default 758, SHALL be the quantized demodulator gain.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 i_in  input  DATA_WIDTH  in-phase sample, FIFO read data.
REQ-007 i_empty  input  1  in-phase FIFO empty.
REQ-008 i_rd_en  output  1  in-phase FIFO pop, combinational.
REQ-009 q_in  input  DATA_WIDTH  quadrature sample, FIFO read data.
REQ-010 q_empty  input  1  quadrature FIFO empty.
REQ-011 q_rd_en  output  1  quadrature FIFO pop, combinational.
REQ-012 y_out  output  DATA_WIDTH  demodulated sample, registered.
REQ-013 y_full  input  1  output FIFO full.
REQ-014 y_wr_en  output  1  output FIFO push, registered.

Function
REQ-015 The block SHALL implement states S_READ, S_CROSS, S_DIV, S_ANGLE, S_WRITE.
REQ-016 S_READ: when i_empty=0 and q_empty=0, i_rd_en and q_rd_en SHALL both be 1 in that cycle, capture (I,Q), go to S_CROSS; otherwise both pops 0 and stay in S_READ, with no single-FIFO pop ever.
REQ-017 S_CROSS (one cycle): re=DEQ(Ip*I + Qp*Q), im=DEQ(Ip*Q - Qp*I), with (Ip,Qp) the previous captured sample; then (Ip,Qp) SHALL be updated to (I,Q).
REQ-018 All products SHALL be 32x32 signed, kept modulo 2^32; all DEQ and division SHALL be signed with truncation toward zero.
REQ-019 S_CROSS SHALL also load the divider: ay=|im|+1; if re>=0, num=QUANT(re-ay), den=re+ay, else num=QUANT(re+ay), den=ay-re.
REQ-020 S_DIV SHALL run a restoring divide on magnitudes for exactly 32 cycles, then apply sign (quotient negative iff num and den signs differ); den is never 0.
REQ-021 S_ANGLE (one cycle): ang=804-DEQ(804*quot) if re>=0, else 2412-DEQ(804*quot); negate ang if im<0; result=DEQ(GAIN*ang).
REQ-022 S_WRITE: if y_full=0, the next edge SHALL set y_out=result, y_wr_en=1 and go to S_READ; else hold in S_WRITE with y_wr_en=0.
REQ-023 y_wr_en SHALL be high for exactly one cycle per sample; y_out SHALL hold its value until the next write.
REQ-024 Latency: pop in cycle T with y_full=0 throughout SHALL give y_wr_en=1 in cycle T+36; minimum sample period 36 cycles.
REQ-025 A pop MAY occur in the same cycle y_wr_en=1 (block already in S_READ).
REQ-026 Input FIFO status SHALL be ignored outside S_READ; y_full SHALL be ignored outside S_WRITE.

Reset
REQ-027 On reset: state=S_READ, Ip=Qp=0, y_out=0, y_wr_en=0, divider registers 0; i_rd_en=q_rd_en=0 while reset asserted.
REQ-028 Reset mid-operation SHALL abandon the in-flight sample without writing it; the first sample after reset SHALL use Ip=Qp=0.

Verification
REQ-029 After reset, (I,Q)=(1024,0) -> y_out=1190, y_wr_en pulse 36 cycles after pop.
REQ-030 Then (1024,0) again -> re=1024, im=0, quot=1022, ang=2, y_out=1.
REQ-031 Prev (1024,0), input (0,1024) -> im=1024, ang=1608, y_out=1190; input (0,-1024) instead -> y_out=-1190 (truncation toward zero).
REQ-032 Only i_empty=0 (q_empty=1) for 50 cycles -> no pops, no writes; then q_empty=0 -> both pop same cycle.
REQ-033 y_full=1 for 20 cycles at S_WRITE -> no write, y_out unchanged; release -> single y_wr_en pulse with correct value.
REQ-034 Reset asserted during S_DIV -> y_wr_en stays 0, outputs 0; next sample (1024,0) -> y_out=1190.
